l2_mem_responder: RTL

- Main-memory responder on the L2 cache's memory-side port.
- Accepts one 128-bit cache-line read or write at a time, holds it for a fixed latency, then completes it with a one-cycle `mem_ready` pulse.
- Holds a line-addressed storage array and is the far end of the `mem_read`/`mem_write`/`mem_addr`/`mem_wdata`/`mem_rdata`/`mem_ready` handshake.
- Used as the memory model under the L2 in system simulation.

---
 rtl/l2_mem_responder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/l2_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : l2_mem_responder
// Brief   : Fixed-latency 128-bit line memory on the L2 memory-side port.
//           Optional MEM_STATS_EN builds saturating read/write completion counters.
// Rev     : 1.0
// ============================================================================
module l2_mem_responder #(
    parameter int LATENCY    = 8,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [27:0]  mem_addr,
    input  logic [127:0] mem_wdata,
    output logic [127:0] mem_rdata,
    output logic         mem_ready,
    output logic [15:0]  rd_cnt,
    output logic [15:0]  wr_cnt
);

    localparam int         c_DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [7:0] c_CNT_LOAD = 8'(LATENCY - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [7:0]            r_cnt;
    logic                  r_is_wr;
    logic [DEPTH_LOG2-1:0] r_addr;
    logic [127:0]          r_wdata;
    logic [127:0]          r_mem [c_DEPTH];

    logic w_accept;
    logic w_complete;
    logic w_commit;
    logic w_load_rd;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (mem_read || mem_write) w_state_nxt = c_BUSY;
            c_BUSY:  if (r_cnt == 8'd0)         w_state_nxt = c_DONE;
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // A simultaneous read and write is taken as a write.
    always_comb begin
        w_accept   = (r_state == c_IDLE) && (mem_read || mem_write);
        w_complete = (r_state == c_BUSY) && (r_cnt == 8'd0);
        w_commit   = w_complete && r_is_wr;
        w_load_rd  = w_complete && !r_is_wr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= 8'd0;
            r_is_wr   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
        end else begin
            mem_ready <= w_complete;
            if (w_accept) begin
                r_cnt   <= c_CNT_LOAD;
                r_is_wr <= mem_write;
                r_addr  <= mem_addr[DEPTH_LOG2-1:0];
                r_wdata <= mem_wdata;
            end else if ((r_state == c_BUSY) && (r_cnt != 8'd0)) begin
                r_cnt <= r_cnt - 8'd1;
            end
            if (w_load_rd) begin
                mem_rdata <= r_mem[r_addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    // Upper line-address bits alias onto the stored range.
    if (DEPTH_LOG2 < 28) begin : g_addr_alias
        logic w_unused_addr_hi;
        assign w_unused_addr_hi = ^mem_addr[27:DEPTH_LOG2];
    end

`ifdef MEM_STATS_EN
    logic [15:0] r_rd_cnt;
    logic [15:0] r_wr_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_cnt <= 16'd0;
            r_wr_cnt <= 16'd0;
        end else begin
            if (w_load_rd && (r_rd_cnt != 16'hFFFF)) r_rd_cnt <= r_rd_cnt + 16'd1;
            if (w_commit  && (r_wr_cnt != 16'hFFFF)) r_wr_cnt <= r_wr_cnt + 16'd1;
        end
    end

    assign rd_cnt = r_rd_cnt;
    assign wr_cnt = r_wr_cnt;
`else
    assign rd_cnt = 16'd0;
    assign wr_cnt = 16'd0;
`endif

endmodule
`default_nettype wire
